// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined ALU with valid/ready handshake,
// pass-through tag and zero / signed-overflow / illegal-opcode flags.
module alu_pipe #(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [2:0]       operation,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out,
    output logic             out_zero,
    output logic             out_ovf,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
);

    localparam int SHW = $clog2(WIDTH);
    localparam int RW  = WIDTH + 1;

    logic             s1_valid_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [2:0]       op_q;
    logic [TAG_W-1:0] tag1_q;

    logic             out_valid_q;
    logic [RW-1:0]    res_q;
    logic             zero_q;
    logic             ovf_q;
    logic             ill_q;
    logic [TAG_W-1:0] tag2_q;

    logic             s2_load;
    logic             s1_advance;

    logic [RW-1:0]    a_x;
    logic [RW-1:0]    b_x;
    logic [RW-1:0]    sum;
    logic [RW-1:0]    diff;
    logic [SHW-1:0]   amt;

    logic [RW-1:0]    res_d;
    logic             zero_d;
    logic             ovf_d;
    logic             ill_d;

    // Stage 2 can take a new beat when empty or draining this cycle;
    // stage 1 can take one when empty or moving forward.
    assign s2_load    = !out_valid_q || out_ready;
    assign s1_advance = s1_valid_q && s2_load;
    assign in_ready   = !rst && (!s1_valid_q || s2_load);

    assign a_x  = {1'b0, a_q};
    assign b_x  = {1'b0, b_q};
    assign sum  = a_x + b_x;
    assign diff = a_x - b_x;
    assign amt  = b_q[SHW-1:0];

    // Result and flags computed from the stage-1 operands.
    always_comb begin
        res_d = '0;
        ovf_d = 1'b0;
        ill_d = 1'b0;
        case (op_q)
            3'd0: begin
                res_d = sum;
                ovf_d = (a_q[WIDTH-1] == b_q[WIDTH-1])
                     && (sum[WIDTH-1] != a_q[WIDTH-1]);
            end
            3'd1: begin
                res_d = diff;
                ovf_d = (a_q[WIDTH-1] != b_q[WIDTH-1])
                     && (diff[WIDTH-1] != a_q[WIDTH-1]);
            end
            3'd2:    res_d = a_x & b_x;
            3'd3:    res_d = a_x | b_x;
            3'd4:    res_d = a_x ^ b_x;
            3'd5:    res_d = a_x << amt;
            3'd6:    res_d = a_x >> amt;
            default: ill_d = 1'b1;
        endcase
        zero_d = (res_d == '0);
    end

    // Stage 1: capture operands, opcode and tag on an input transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
        end else if (in_ready) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                a_q    <= in1;
                b_q    <= in2;
                op_q   <= operation;
                tag1_q <= in_tag;
            end
        end
    end

    // Stage 2: register result and flags; hold them while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            res_q       <= '0;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
            ill_q       <= 1'b0;
            tag2_q      <= '0;
        end else if (s2_load) begin
            out_valid_q <= s1_valid_q;
            if (s1_advance) begin
                res_q  <= res_d;
                zero_q <= zero_d;
                ovf_q  <= ovf_d;
                ill_q  <= ill_d;
                tag2_q <= tag1_q;
            end
        end
    end

    assign out_valid   = out_valid_q;
    assign out         = res_q;
    assign out_zero    = zero_q;
    assign out_ovf     = ovf_q;
    assign out_illegal = ill_q;
    assign out_tag     = tag2_q;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed and randomized checks of alu_pipe against
// an arithmetic reference model and an in-order scoreboard.
module tb_alu_pipe;

    localparam int W  = 16;
    localparam int TW = 4;

    typedef struct {
        logic [W:0]    r;
        logic [2:0]    zoi;
        logic [TW-1:0] tag;
        int            cyc;
    } exp_t;

    typedef struct {
        logic [2:0]    op;
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [TW-1:0] tag;
        logic [W:0]    r;
        logic [2:0]    zoi;
    } dir_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in1;
    logic [W-1:0]  in2;
    logic [2:0]    operation;
    logic [TW-1:0] in_tag;
    logic          out_valid;
    logic          out_ready;
    logic [W:0]    out;
    logic          out_zero;
    logic          out_ovf;
    logic          out_illegal;
    logic [TW-1:0] out_tag;

    int   n_chk = 0;
    int   n_err = 0;
    int   n_pop = 0;
    int   cyc   = 0;
    int   last_lat;
    logic [W:0]    last_out;
    logic [2:0]    last_zoi;
    logic [TW-1:0] last_tag;
    exp_t sb[$];
    bit   rnd_done;

    alu_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in1        (in1),
        .in2        (in2),
        .operation  (operation),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out        (out),
        .out_zero   (out_zero),
        .out_ovf    (out_ovf),
        .out_illegal(out_illegal),
        .out_tag    (out_tag)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Reference: signed/unsigned arithmetic on wide integers.
    function automatic exp_t model(input logic [2:0] op, input longint a,
                                   input longint b, input logic [TW-1:0] tag);
        exp_t   e;
        longint m    = (longint'(1) << (W + 1)) - 1;
        longint half = longint'(1) << (W - 1);
        longint full = longint'(1) << W;
        longint shm  = longint'(1) << $clog2(W);
        longint sa   = (a >= half) ? a - full : a;
        longint sb_  = (b >= half) ? b - full : b;
        longint r    = 0;
        longint s    = 0;
        bit     ovf  = 0;
        bit     ill  = 0;
        int     amt  = int'(b % shm);
        case (op)
            3'd0: begin r = a + b; s = sa + sb_; ovf = (s < -half) || (s >= half); end
            3'd1: begin r = a - b; s = sa - sb_; ovf = (s < -half) || (s >= half); end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = a << amt;
            3'd6: r = a >> amt;
            default: begin r = 0; ill = 1; end
        endcase
        r     = r & m;
        e.r   = r[W:0];
        e.zoi = {r == 0, ovf, ill};
        e.tag = tag;
        e.cyc = 0;
        return e;
    endfunction

    // Output monitor: scoreboard compare and stall stability.
    initial begin
        bit            stall = 0;
        logic [W:0]    p_out;
        logic [2:0]    p_zoi;
        logic [TW-1:0] p_tag;
        exp_t          e;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall = 0;
            end else begin
                if (stall) begin
                    check("hold_valid", out_valid, 1);
                    check("hold_out", out, p_out);
                    check("hold_flags", {out_zero, out_ovf, out_illegal}, p_zoi);
                    check("hold_tag", out_tag, p_tag);
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        check("spurious_out", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        check("out", out, e.r);
                        check("flags", {out_zero, out_ovf, out_illegal}, e.zoi);
                        check("tag", out_tag, e.tag);
                        last_lat = cyc - e.cyc;
                        last_out = out;
                        last_zoi = {out_zero, out_ovf, out_illegal};
                        last_tag = out_tag;
                        n_pop++;
                    end
                end
                stall = out_valid && !out_ready;
                p_out = out;
                p_zoi = {out_zero, out_ovf, out_illegal};
                p_tag = out_tag;
            end
        end
    end

    // Present one beat; called at posedge+1, returns at posedge+1.
    task automatic send(input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [TW-1:0] tag);
        exp_t e;
        bit   ok = 0;
        int   n  = 0;
        in_valid  = 1'b1;
        in1       = a;
        in2       = b;
        operation = op;
        in_tag    = tag;
        while (!ok && n < 100) begin
            @(negedge clk);
            if (in_ready) begin
                e     = model(op, longint'(a), longint'(b), tag);
                e.cyc = cyc;
                sb.push_back(e);
                ok = 1;
            end
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (!ok) check("accept_timeout", 0, 1);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(4))
            0:       return '0;
            1:       return 16'hFFFF;
            2:       return 16'h7FFF;
            3:       return 16'h8000;
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        dir_t dv[8];
        int   base;
        dv[0] = '{3'd0, 16'hFFFF, 16'h0001, 4'h1, 17'h10000, 3'b000};
        dv[1] = '{3'd0, 16'h7FFF, 16'h0001, 4'h2, 17'h08000, 3'b010};
        dv[2] = '{3'd1, 16'h0003, 16'h0005, 4'h3, 17'h1FFFE, 3'b000};
        dv[3] = '{3'd1, 16'h0005, 16'h0005, 4'h4, 17'h00000, 3'b100};
        dv[4] = '{3'd1, 16'h8000, 16'h0001, 4'h5, 17'h07FFF, 3'b010};
        dv[5] = '{3'd5, 16'h8001, 16'h0011, 4'h6, 17'h10002, 3'b000};
        dv[6] = '{3'd6, 16'h8000, 16'h000F, 4'h7, 17'h00001, 3'b000};
        dv[7] = '{3'd7, 16'h1234, 16'h5678, 4'hA, 17'h00000, 3'b101};

        rst       = 1'b1;
        in_valid  = 1'b1;
        in1       = 16'h0001;
        in2       = 16'h0002;
        operation = 3'd0;
        in_tag    = 4'hF;
        out_ready = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("rst_in_ready", in_ready, 0);
            check("rst_out_valid", out_valid, 0);
            check("rst_out", out, 0);
            check("rst_flags", {out_zero, out_ovf, out_illegal}, 0);
            check("rst_tag", out_tag, 0);
        end
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("rel_in_ready", in_ready, 1);
        check("rel_no_out", out_valid, 0);
        @(posedge clk);
        #1;

        foreach (dv[i]) begin
            send(dv[i].op, dv[i].a, dv[i].b, dv[i].tag);
            drain();
            check("dir_lat", last_lat, 2);
            check("dir_out", last_out, dv[i].r);
            check("dir_flags", last_zoi, dv[i].zoi);
            check("dir_tag", last_tag, dv[i].tag);
        end

        base = n_pop;
        fork
            begin
                for (int t = 0; t < 6; t++)
                    send(3'($urandom_range(6)), pick(), pick(), TW'(t));
            end
            begin
                int n = 0;
                do begin
                    @(posedge clk);
                    #1;
                    n++;
                end while (!out_valid && n < 50);
                if (!out_valid) check("bp_first_timeout", 0, 1);
                out_ready = 1'b0;
                repeat (4) begin
                    @(negedge clk);
                    check("bp_in_ready", in_ready, 0);
                    check("bp_valid", out_valid, 1);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        check("bp_count", n_pop - base, 6);

        out_ready = 1'b0;
        send(3'd0, 16'h0011, 16'h0022, 4'hB);
        send(3'd1, 16'h0100, 16'h0001, 4'hC);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        base = n_pop;
        @(negedge clk);
        check("mid_rst_valid", out_valid, 0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("mid_rst_no_out", n_pop - base, 0);
        send(3'd3, 16'h0F00, 16'h00F0, 4'hD);
        drain();
        check("mid_rst_lat", last_lat, 2);
        check("mid_rst_out", last_out, 17'h00FF0);
        check("mid_rst_tag", last_tag, 4'hD);

        rnd_done = 0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    if ($urandom_range(3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    send(3'($urandom_range(7)), pick(), pick(),
                         TW'($urandom));
                end
                rnd_done = 1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();
        check("final_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
